bpm_tempo_ctrl: RTL and testbench
=================================

// Module: bpm_tempo_ctrl
// PURPOSE
//  Tempo controller that sits in front of the BPM clock generator and sequences its bpm_inc/bpm_dec inputs.
//  - Turns synchronized, debounced button levels into single-cycle step pulses.
//  - Supports press-and-hold auto-repeat.
//  - Arbitrates simultaneous up/down presses.
//  - Keeps a shadow BPM so that no step is ever issued beyond MIN_BPM/MAX_BPM.
// PARAMETERS
//  CLOCK_FREQ   100_000_000  clk frequency in Hz; derives ms timers (cycles per ms = CLOCK_FREQ/1000)
//  DEFAULT_BPM  120          shadow BPM after reset; must match the clock generator's reset BPM
//  MIN_BPM      40           lowest legal tempo
//  MAX_BPM      200          highest legal tempo
//  STEP         10           BPM change per pulse; must match the generator's step size
//  HOLD_MS      500          hold time before auto-repeat starts
//  REPEAT_MS    100          auto-repeat interval
// PORTS
//  clk        in   1  system clock
//  reset_n    in   1  asynchronous active-low reset
//  btn_up     in   1  up button level; already synchronized and debounced
//  btn_down   in   1  down button level; already synchronized and debounced
//  beat_edge  in   1  1-cycle pulse on each quarter-note boundary from the clock generator
//  bpm_inc    out  1  1-cycle step-up pulse to the generator
//  bpm_dec    out  1  1-cycle step-down pulse to the generator
//  bpm_shadow out  8  controller's view of the current BPM
//  pending    out  1  a step is queued but not yet issued
// BEHAVIOUR
//  Reset (async on reset_n low; outputs registered):
//   - bpm_inc=0, bpm_dec=0, pending=0, bpm_shadow=DEFAULT_BPM, FSM=IDLE, timer=0.
//   - Reset asserted mid-hold or with a step queued discards all state.
//   - A button still held when reset deasserts is ignored until it is released: FSM enters WAIT_REL.
//  FSM states IDLE, HOLD, REPEAT, WAIT_REL:
//   - IDLE: on exactly one button high, request 1 step in that direction, clear timer, go to HOLD.
//     If both buttons are high, go to WAIT_REL with no request.
//   - HOLD: timer counts cycles.
//     When timer reaches HOLD_MS*CLOCK_FREQ/1000-1, request 1 step, clear timer, go to REPEAT.
//   - REPEAT: request 1 step every REPEAT_MS*CLOCK_FREQ/1000 cycles.
//   - HOLD/REPEAT: if the active button is released -> IDLE.
//     If the opposite button rises -> WAIT_REL; no request that cycle.
//   - WAIT_REL: stay until both buttons are low, then go to IDLE.
//  Request/issue rules:
//   - A request is legal only if the shadow BPM can take it:
//     up needs bpm_shadow+STEP<=MAX_BPM; down needs bpm_shadow-STEP>=MIN_BPM.
//   - Illegal requests are dropped silently. At a limit a held button produces no pulses, but the FSM keeps running.
//   - Single queue slot (pend_dir).
//     A same-direction request while a step is pending is dropped.
//     An opposite-direction request cancels the pending step; the slot ends empty.
//   - Issuing a step: the pulse (bpm_inc or bpm_dec) is high for exactly 1 cycle.
//     bpm_shadow updates by ±STEP in the same cycle as the pulse.
//     pending clears in that cycle.
//   - bpm_inc and bpm_dec are never high together.
//     Pulses are at least 2 cycles apart, so the generator never sees back-to-back edges.
//   - Legality is checked against the shadow value including any pending step. Shadow arithmetic uses 9 bits, so no wrap.
//  Timer: width $clog2(HOLD_MS*CLOCK_FREQ/1000+1); saturates, never wraps.
//  Simultaneous events:
//   - A new request and the issue of the old one in the same cycle: issue first, new request queued.
//   - beat_edge with an empty queue has no effect.
// CONFIGURATION
//  BEAT_QUANTIZE_EN defined:
//   - A queued step is issued only on the cycle after beat_edge, so tempo changes land on quarter-note boundaries.
//   - pending stays high from request until that issue.
//  BEAT_QUANTIZE_EN undefined:
//   - beat_edge is ignored; a legal request issues a pulse 1 cycle after the request.
//   - pending is high for that single cycle.
// TESTING  (CLOCK_FREQ=1000, HOLD_MS=5, REPEAT_MS=2, BEAT_QUANTIZE_EN off unless noted)
//  1. Reset, btn_up high for 1 cycle
//     -> exactly 1 bpm_inc pulse; bpm_shadow 120->130; no bpm_dec.
//  2. btn_up held 12 cycles from 120
//     -> pulses at press+1, +6, +8, +10, +12; bpm_shadow=170.
//  3. Shadow at 200, btn_up held 20 cycles
//     -> zero bpm_inc; bpm_shadow stays 200.
//     Repeat at 40 with btn_down -> zero bpm_dec.
//  4. btn_up and btn_down rise on the same cycle, held 10 cycles, then released
//     -> no pulses; FSM back in IDLE.
//     A following btn_down press -> 1 bpm_dec.
//  5. BEAT_QUANTIZE_EN on, btn_up pulse, beat_edge 7 cycles later
//     -> pending=1 for 8 cycles; bpm_inc on the cycle after beat_edge.
//     A btn_down while pending -> pending=0 and no pulse.
//  6. reset_n low mid-REPEAT with a pending step
//     -> outputs immediately at reset values.
//     Release reset with btn_up still high -> no pulse until btn_up is cycled.

Source files
------------

// File: rtl/bpm_tempo_ctrl.sv
// Tempo step sequencer in front of the BPM clock generator: button levels -> single-cycle inc/dec pulses.
// Define BEAT_QUANTIZE_EN to hold queued steps until the cycle after beat_edge.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no button active; first press requests one step
// HOLD     | button held; counting towards auto-repeat start
// REPEAT   | auto-repeat; one step request per repeat interval
// WAIT_REL | ignoring buttons until both are released
module bpm_tempo_ctrl #(
    parameter int CLOCK_FREQ  = 100_000_000,
    parameter int DEFAULT_BPM = 120,
    parameter int MIN_BPM     = 40,
    parameter int MAX_BPM     = 200,
    parameter int STEP        = 10,
    parameter int HOLD_MS     = 500,
    parameter int REPEAT_MS   = 100
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       beat_edge,
    output logic       bpm_inc,
    output logic       bpm_dec,
    output logic [7:0] bpm_shadow,
    output logic       pending
);

`ifdef BEAT_QUANTIZE_EN
    localparam bit QUANT = 1'b1;
`else
    localparam bit QUANT = 1'b0;
`endif

    localparam longint HOLD_CYC = longint'(HOLD_MS) * longint'(CLOCK_FREQ) / 1000;
    localparam longint REP_CYC  = longint'(REPEAT_MS) * longint'(CLOCK_FREQ) / 1000;
    localparam int     TW       = $clog2(HOLD_CYC + 1);

    localparam logic [TW-1:0] HOLD_TC  = TW'(HOLD_CYC - 1);
    localparam logic [TW-1:0] REP_TC   = TW'(REP_CYC - 1);
    localparam logic [TW-1:0] TMAX     = {TW{1'b1}};
    localparam logic [8:0]    STEP9    = 9'(STEP);
    localparam logic [8:0]    MAX9     = 9'(MAX_BPM);
    localparam logic [8:0]    MIN_LIM9 = 9'(MIN_BPM + STEP);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_HOLD     = 2'd1,
        S_REPEAT   = 2'd2,
        S_WAIT_REL = 2'd3
    } state_t;

    state_t          state, state_nx;
    logic [TW-1:0]   timer, timer_nx;
    logic            act_up, act_up_nx;
    logic            first_cyc;
    logic            req_up, req_dn;
    logic            act_btn, opp_btn;

    logic            slot_full, slot_full_nx;
    logic            slot_up, slot_up_nx;
    logic            inc_nx, dec_nx, pend_nx;
    logic [8:0]      shadow9, eff, shadow_nx;
    logic            legal_up, legal_dn, can_issue;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            timer     <= '0;
            act_up    <= 1'b0;
            first_cyc <= 1'b1;
        end else begin
            state     <= state_nx;
            timer     <= timer_nx;
            act_up    <= act_up_nx;
            first_cyc <= 1'b0;
        end
    end

    always_comb begin
        state_nx  = state;
        timer_nx  = timer;
        act_up_nx = act_up;
        req_up    = 1'b0;
        req_dn    = 1'b0;
        act_btn   = act_up ? btn_up : btn_down;
        opp_btn   = act_up ? btn_down : btn_up;
        case (state)
            S_IDLE: begin
                timer_nx = '0;
                // A button already down when reset lifts must be released first
                if ((first_cyc && (btn_up || btn_down)) || (btn_up && btn_down)) begin
                    state_nx = S_WAIT_REL;
                end else if (btn_up) begin
                    req_up    = 1'b1;
                    act_up_nx = 1'b1;
                    state_nx  = S_HOLD;
                end else if (btn_down) begin
                    req_dn    = 1'b1;
                    act_up_nx = 1'b0;
                    state_nx  = S_HOLD;
                end
            end
            S_HOLD, S_REPEAT: begin
                if (opp_btn) begin
                    state_nx = S_WAIT_REL;
                    timer_nx = '0;
                end else if (!act_btn) begin
                    state_nx = S_IDLE;
                    timer_nx = '0;
                end else if ((state == S_HOLD && timer == HOLD_TC) ||
                             (state == S_REPEAT && timer == REP_TC)) begin
                    req_up   = act_up;
                    req_dn   = !act_up;
                    timer_nx = '0;
                    state_nx = S_REPEAT;
                end else if (timer != TMAX) begin
                    timer_nx = timer + TW'(1);
                end
            end
            S_WAIT_REL: begin
                timer_nx = '0;
                if (!btn_up && !btn_down) state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
                timer_nx = '0;
            end
        endcase
    end

    assign shadow9 = {1'b0, bpm_shadow};

    // Legality is judged against the shadow as it will be once the queued step lands
    always_comb begin
        eff = shadow9;
        if (slot_full) eff = slot_up ? shadow9 + STEP9 : shadow9 - STEP9;
        legal_up  = req_up && ((eff + STEP9) <= MAX9);
        legal_dn  = req_dn && (eff >= MIN_LIM9);
        can_issue = !(bpm_inc || bpm_dec) && (!QUANT || beat_edge);

        inc_nx       = 1'b0;
        dec_nx       = 1'b0;
        shadow_nx    = shadow9;
        slot_full_nx = slot_full;
        slot_up_nx   = slot_up;

        if (slot_full && can_issue) begin
            inc_nx       = slot_up;
            dec_nx       = !slot_up;
            shadow_nx    = eff;
            slot_full_nx = legal_up || legal_dn;
            slot_up_nx   = legal_up;
        end else if (slot_full) begin
            if ((legal_up && !slot_up) || (legal_dn && slot_up)) slot_full_nx = 1'b0;
        end else if (legal_up || legal_dn) begin
            if (can_issue && !QUANT) begin
                inc_nx    = legal_up;
                dec_nx    = legal_dn;
                shadow_nx = legal_up ? shadow9 + STEP9 : shadow9 - STEP9;
            end else begin
                slot_full_nx = 1'b1;
                slot_up_nx   = legal_up;
            end
        end
        pend_nx = slot_full_nx || inc_nx || dec_nx;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bpm_inc    <= 1'b0;
            bpm_dec    <= 1'b0;
            pending    <= 1'b0;
            bpm_shadow <= 8'(DEFAULT_BPM);
            slot_full  <= 1'b0;
            slot_up    <= 1'b0;
        end else begin
            bpm_inc    <= inc_nx;
            bpm_dec    <= dec_nx;
            pending    <= pend_nx;
            bpm_shadow <= shadow_nx[7:0];
            slot_full  <= slot_full_nx;
            slot_up    <= slot_up_nx;
        end
    end

endmodule

// File: tb/tb_bpm_tempo_ctrl.sv
// Bench for bpm_tempo_ctrl: directed scenarios plus random button/beat traffic against a press-age model.
// Quantized scenarios are used when BEAT_QUANTIZE_EN is defined.
module tb_bpm_tempo_ctrl;
    localparam int CF   = 1000;
    localparam int HMS  = 5;
    localparam int RMS  = 2;
    localparam int DEF  = 120;
    localparam int MINB = 40;
    localparam int MAXB = 200;
    localparam int STP  = 10;
    localparam int H    = HMS * CF / 1000;
    localparam int R    = RMS * CF / 1000;
`ifdef BEAT_QUANTIZE_EN
    localparam bit QUANT = 1'b1;
`else
    localparam bit QUANT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n, btn_up, btn_down, beat_edge;
    logic       bpm_inc, bpm_dec, pending;
    logic [7:0] bpm_shadow;

    always #5 clk = ~clk;

    bpm_tempo_ctrl #(
        .CLOCK_FREQ(CF), .DEFAULT_BPM(DEF), .MIN_BPM(MINB), .MAX_BPM(MAXB),
        .STEP(STP), .HOLD_MS(HMS), .REPEAT_MS(RMS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .btn_up(btn_up), .btn_down(btn_down),
        .beat_edge(beat_edge), .bpm_inc(bpm_inc), .bpm_dec(bpm_dec),
        .bpm_shadow(bpm_shadow), .pending(pending)
    );

    int errors = 0;
    int checks = 0;

    // Model: press age counts held cycles; slot is the one queued direction (+1/-1/0)
    int m_shadow, m_active, m_age, m_slot, m_last;
    bit m_blocked, m_first;
    bit e_inc, e_dec, e_pend;

    int          n_inc, n_dec, n_pend, step_idx;
    logic [31:0] inc_mask;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_shadow = DEF; m_active = 0; m_age = 0; m_slot = 0; m_last = 0;
        m_blocked = 0; m_first = 1;
    endtask

    task automatic model_cycle(input logic u, input logic d, input logic b);
        int req, eff, p;
        bit legal, can, act, opp;
        req = 0;
        if (m_blocked) begin
            if (!u && !d) m_blocked = 0;
        end else if (m_active == 0) begin
            if (u || d) begin
                if (m_first || (u && d)) m_blocked = 1;
                else begin
                    m_active = u ? 1 : -1;
                    m_age = 0;
                    req = m_active;
                end
            end
        end else begin
            act = (m_active == 1) ? u : d;
            opp = (m_active == 1) ? d : u;
            if (opp) begin
                m_blocked = 1;
                m_active = 0;
            end else if (!act) begin
                m_active = 0;
            end else begin
                m_age++;
                if (m_age >= H && (m_age - H) % R == 0) req = m_active;
            end
        end
        m_first = 0;

        eff   = m_shadow + m_slot * STP;
        legal = (req != 0) && (eff + req * STP <= MAXB) && (eff + req * STP >= MINB);
        can   = (m_last == 0) && (!QUANT || b);
        p = 0;
        if (m_slot != 0 && can) begin
            p = m_slot;
            m_shadow = eff;
            m_slot = legal ? req : 0;
        end else if (m_slot != 0) begin
            if (legal && req != m_slot) m_slot = 0;
        end else if (legal) begin
            if (can && !QUANT) begin
                p = req;
                m_shadow = eff + req * STP;
            end else begin
                m_slot = req;
            end
        end
        m_last = p;
        e_inc  = (p == 1);
        e_dec  = (p == -1);
        e_pend = (m_slot != 0) || (p != 0);
    endtask

    task automatic step(input logic u, input logic d, input logic b);
        @(negedge clk);
        btn_up = u; btn_down = d; beat_edge = b;
        model_cycle(u, d, b);
        @(posedge clk);
        #1;
        chk("bpm_inc", 32'(bpm_inc), 32'(e_inc));
        chk("bpm_dec", 32'(bpm_dec), 32'(e_dec));
        chk("pending", 32'(pending), 32'(e_pend));
        chk("bpm_shadow", 32'(bpm_shadow), 32'(m_shadow));
        if (bpm_inc === 1'b1) begin
            n_inc++;
            if (step_idx < 32) inc_mask[step_idx] = 1'b1;
        end
        if (bpm_dec === 1'b1) n_dec++;
        if (pending === 1'b1) n_pend++;
        step_idx++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic hold(input logic u, input logic d, input int n);
        for (int i = 0; i < n; i++) step(u, d, 1'b0);
    endtask

    task automatic clear_counts();
        n_inc = 0; n_dec = 0; n_pend = 0; step_idx = 0; inc_mask = '0;
    endtask

    // Called just after a check point; asserts reset mid-cycle and checks outputs asynchronously
    task automatic async_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_inc", 32'(bpm_inc), 0);
        chk("rst_dec", 32'(bpm_dec), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_shadow", 32'(bpm_shadow), DEF);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic u, d;
        reset_n = 1'b0; btn_up = 1'b0; btn_down = 1'b0; beat_edge = 1'b0;
        clear_counts();
        repeat (2) @(posedge clk);
        #1;
        chk("init_inc", 32'(bpm_inc), 0);
        chk("init_pending", 32'(pending), 0);
        chk("init_shadow", 32'(bpm_shadow), DEF);
        reset_n = 1'b1;
        model_reset();

`ifndef BEAT_QUANTIZE_EN
        // Single tap
        idle(3);
        clear_counts();
        step(1'b1, 1'b0, 1'b0);
        idle(4);
        chk("tap_inc_count", n_inc, 1);
        chk("tap_dec_count", n_dec, 0);
        chk("tap_shadow", 32'(bpm_shadow), 130);

        // Hold 12 cycles from 120: pulses after press cycles 0,5,7,9,11
        async_reset();
        idle(2);
        clear_counts();
        hold(1'b1, 1'b0, 12);
        idle(2);
        chk("hold_pulse_cycles", inc_mask, 32'h0000_0AA1);
        chk("hold_shadow", 32'(bpm_shadow), 170);

        // Upper limit
        hold(1'b1, 1'b0, 10);
        idle(2);
        chk("max_reach_shadow", 32'(bpm_shadow), MAXB);
        clear_counts();
        hold(1'b1, 1'b0, 20);
        idle(2);
        chk("max_hold_inc", n_inc, 0);
        chk("max_hold_shadow", 32'(bpm_shadow), MAXB);

        // Lower limit
        hold(1'b0, 1'b1, 40);
        idle(2);
        chk("min_reach_shadow", 32'(bpm_shadow), MINB);
        clear_counts();
        hold(1'b0, 1'b1, 20);
        idle(2);
        chk("min_hold_dec", n_dec, 0);
        chk("min_hold_shadow", 32'(bpm_shadow), MINB);

        // Both buttons together
        async_reset();
        idle(2);
        clear_counts();
        hold(1'b1, 1'b1, 10);
        idle(2);
        chk("both_inc", n_inc, 0);
        chk("both_dec", n_dec, 0);
        step(1'b0, 1'b1, 1'b0);
        idle(3);
        chk("after_both_dec", n_dec, 1);
        chk("after_both_shadow", 32'(bpm_shadow), 110);

        // Reset mid-repeat while a step is in flight, button held through reset
        async_reset();
        idle(2);
        hold(1'b1, 1'b0, 8);
        chk("pre_rst_pending", 32'(pending), 1);
        async_reset();
        clear_counts();
        hold(1'b1, 1'b0, 10);
        chk("held_thru_rst_inc", n_inc, 0);
        idle(1);
        step(1'b1, 1'b0, 1'b0);
        idle(2);
        chk("recycled_inc", n_inc, 1);
`else
        // Quantized: step lands on the cycle after beat_edge
        idle(3);
        clear_counts();
        step(1'b1, 1'b0, 1'b0);
        idle(6);
        step(1'b0, 1'b0, 1'b1);
        idle(3);
        chk("q_pending_cycles", n_pend, 8);
        chk("q_inc_count", n_inc, 1);
        chk("q_shadow", 32'(bpm_shadow), 130);

        // Opposite request cancels the queued step
        clear_counts();
        step(1'b1, 1'b0, 1'b0);
        idle(1);
        step(1'b0, 1'b1, 1'b0);
        chk("q_cancel_pending", 32'(pending), 0);
        idle(3);
        step(1'b0, 1'b0, 1'b1);
        idle(3);
        chk("q_cancel_inc", n_inc, 0);
        chk("q_cancel_dec", n_dec, 0);
        chk("q_cancel_shadow", 32'(bpm_shadow), 130);
`endif

        // Random traffic
        async_reset();
        u = 1'b0; d = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) u = ~u;
            if ($urandom_range(0, 11) == 0) d = ~d;
            step(u, d, ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
